// File: rtl/range_coalesce.sv
// range_coalesce: merges a sorted stream of inclusive ID ranges (two lanes per beat) into
// disjoint ranges, queues them in an output FIFO and totals the covered IDs.
// Optional build macro RANGE_COALESCE_ADJ_MERGE_EN also coalesces touching ranges.
module range_coalesce #(
  parameter int DATA_WIDTH     = 64,
  parameter int TOTAL_WIDTH    = 64,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    data_valid_in,
  output logic                    data_ready_out,
  input  logic [2*DATA_WIDTH-1:0] even_data_in,
  input  logic [2*DATA_WIDTH-1:0] odd_data_in,
  input  logic                    odd_valid_in,
  input  logic                    stream_done_in,
  output logic [2*DATA_WIDTH-1:0] merged_out,
  output logic                    merged_valid_out,
  input  logic                    merged_ready_in,
  output logic [TOTAL_WIDTH-1:0]  total_out,
  output logic                    done_out,
  output logic                    order_err_out,
  output logic [1:0]              fsm_state_out
);
  localparam int W     = DATA_WIDTH;
  localparam int PTR_W = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(OUT_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(OUT_FIFO_DEPTH - 2);

  typedef struct packed {
    logic [W-1:0] first;
    logic [W-1:0] second;
  } range_t;

  typedef struct packed {
    range_t cur;
    logic   push;
    range_t out;
    logic   err;
  } step_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Merge limit is widened by one bit so an all-ones cur.second never wraps.
  function automatic logic can_merge(input range_t c, input range_t n);
    logic [W:0] lim;
`ifdef RANGE_COALESCE_ADJ_MERGE_EN
    lim = {1'b0, c.second} + {{W{1'b0}}, 1'b1};
`else
    lim = {1'b0, c.second};
`endif
    return ({1'b0, n.first} <= lim);
  endfunction

  function automatic logic [TOTAL_WIDTH-1:0] span(input range_t r);
    logic [W:0] s;
    s = {1'b0, r.second} - {1'b0, r.first} + {{W{1'b0}}, 1'b1};
    return TOTAL_WIDTH'(s);
  endfunction

  function automatic step_t merge_step(input logic cur_v, input range_t c, input range_t n);
    step_t r;
    r.cur  = n;
    r.push = 1'b0;
    r.out  = c;
    r.err  = 1'b0;
    if (cur_v) begin
      r.err = (n.first < c.first);
      if (can_merge(c, n)) begin
        r.cur = c;
        if (n.second > c.second) r.cur.second = n.second;
      end else begin
        r.push = 1'b1;
      end
    end
    return r;
  endfunction

  state_t                 state_q, state_d;
  range_t                 cur_q, cur_d;
  logic                   cur_valid_q, cur_valid_d;
  logic [TOTAL_WIDTH-1:0] total_q, total_d;
  logic                   order_err_q, order_err_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, wr_ptr_b;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  range_t                 mem [OUT_FIFO_DEPTH];

  range_t                 even_r, odd_r;
  step_t                  s_even, s_odd;
  logic                   accept, pop;
  logic                   p0, p1;
  logic                   push_a, push_b;
  range_t                 wdata_a, wdata_b;
  logic [TOTAL_WIDTH-1:0] add_a, add_b;

  assign even_r = even_data_in;
  assign odd_r  = odd_data_in;

  // Handshake: input beat transfers on a rising edge where data_valid_in && data_ready_out;
  // a FIFO entry pops on a rising edge where merged_valid_out && merged_ready_in.
  assign merged_valid_out = (count_q != '0);
  assign data_ready_out   = ((state_q == IDLE) || (state_q == ACCUM)) && (count_q <= READY_MAX);
  assign merged_out       = mem[rd_ptr_q];
  assign total_out        = total_q;
  assign done_out         = (state_q == DONE);
  assign order_err_out    = order_err_q;
  assign fsm_state_out    = state_q;
  assign wr_ptr_b         = wr_ptr_q + PTR_W'(1);

  always_comb begin
    accept = data_valid_in && data_ready_out;
    pop    = merged_valid_out && merged_ready_in;
    s_even = merge_step(cur_valid_q, cur_q, even_r);
    s_odd  = merge_step(1'b1, s_even.cur, odd_r);
    p0     = s_even.push;
    p1     = odd_valid_in && s_odd.push;

    state_d     = state_q;
    cur_d       = cur_q;
    cur_valid_d = cur_valid_q;
    order_err_d = order_err_q;
    push_a      = 1'b0;
    push_b      = 1'b0;
    wdata_a     = s_even.out;
    wdata_b     = s_odd.out;
    add_a       = '0;
    add_b       = '0;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          state_d     = ACCUM;
          cur_valid_d = 1'b1;
          cur_d       = odd_valid_in ? s_odd.cur : s_even.cur;
          // Lane order is preserved: an even closure always occupies the first slot.
          push_a      = p0 || p1;
          push_b      = p0 && p1;
          wdata_a     = p0 ? s_even.out : s_odd.out;
          add_a       = p0 ? span(s_even.out) : '0;
          add_b       = p1 ? span(s_odd.out) : '0;
          if (s_even.err || (odd_valid_in && s_odd.err)) order_err_d = 1'b1;
        end else if ((state_q == IDLE) && stream_done_in) begin
          state_d = DONE;
        end else if ((state_q == ACCUM) && stream_done_in && !data_valid_in) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (count_q < DEPTH_C) begin
          push_a      = cur_valid_q;
          wdata_a     = cur_q;
          add_a       = cur_valid_q ? span(cur_q) : '0;
          cur_valid_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    total_d  = total_q + add_a + add_b;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_a) + PTR_W'(push_b);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      cur_valid_q <= 1'b0;
      total_q     <= '0;
      order_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      cur_valid_q <= cur_valid_d;
      total_q     <= total_d;
      order_err_q <= order_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: count_q gates visibility of every entry.
  always_ff @(posedge clock) begin
    if (push_a) mem[wr_ptr_q] <= wdata_a;
    if (push_b) mem[wr_ptr_b] <= wdata_b;
  end

endmodule

// File: tb/tb_range_coalesce.sv
// Directed testbench for range_coalesce: hand-computed merged streams, totals and flags.
module tb_range_coalesce;
  localparam int W  = 64;
  localparam int TW = 64;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            data_valid_in;
  logic            data_ready_out;
  logic [2*W-1:0]  even_data_in;
  logic [2*W-1:0]  odd_data_in;
  logic            odd_valid_in;
  logic            stream_done_in;
  logic [2*W-1:0]  merged_out;
  logic            merged_valid_out;
  logic            merged_ready_in;
  logic [TW-1:0]   total_out;
  logic            done_out;
  logic            order_err_out;
  logic [1:0]      fsm_state_out;

  logic [2*W-1:0]  exp_q[$];
  logic [2*W-1:0]  got_q[$];
  int              tests = 0;
  int              fails = 0;

  range_coalesce #(.DATA_WIDTH(W), .TOTAL_WIDTH(TW), .OUT_FIFO_DEPTH(4)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .data_valid_in   (data_valid_in),
    .data_ready_out  (data_ready_out),
    .even_data_in    (even_data_in),
    .odd_data_in     (odd_data_in),
    .odd_valid_in    (odd_valid_in),
    .stream_done_in  (stream_done_in),
    .merged_out      (merged_out),
    .merged_valid_out(merged_valid_out),
    .merged_ready_in (merged_ready_in),
    .total_out       (total_out),
    .done_out        (done_out),
    .order_err_out   (order_err_out),
    .fsm_state_out   (fsm_state_out)
  );

  always #5 clock = ~clock;

  function automatic logic [2*W-1:0] rng(input logic [W-1:0] f, input logic [W-1:0] s);
    return {f, s};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_n         = 1'b0;
    data_valid_in   = 1'b0;
    odd_valid_in    = 1'b0;
    stream_done_in  = 1'b0;
    merged_ready_in = 1'b0;
    even_data_in    = '0;
    odd_data_in     = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_beat(input logic [2*W-1:0] ev, input logic [2*W-1:0] od, input logic ov);
    int guard = 0;
    data_valid_in = 1'b1;
    even_data_in  = ev;
    odd_data_in   = od;
    odd_valid_in  = ov;
    @(negedge clock);
    while (!data_ready_out && guard < 200) begin
      guard++;
      @(negedge clock);
    end
    if (guard >= 200) begin
      tests++; fails++;
      $display("FAIL send_beat_timeout: data_ready_out stayed %0b, required 1", data_ready_out);
    end
    @(posedge clock);
    #1;
    data_valid_in = 1'b0;
    odd_valid_in  = 1'b0;
  endtask

  task automatic finish_stream();
    int guard = 0;
    stream_done_in = 1'b1;
    while (!done_out && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!done_out) begin
      tests++; fails++;
      $display("FAIL done_timeout: done_out=%0b, required 1", done_out);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic collect(input int n);
    int guard = 0;
    merged_ready_in = 1'b1;
    while (got_q.size() < n && guard < 300) begin
      @(negedge clock);
      if (merged_valid_out) got_q.push_back(merged_out);
      guard++;
      @(posedge clock);
      #1;
    end
    merged_ready_in = 1'b0;
    if (got_q.size() < n) begin
      tests++; fails++;
      $display("FAIL collect_timeout: got %0d entries, required %0d", got_q.size(), n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clock);
    tests++; if (merged_valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b, required 0", merged_valid_out); end
    tests++; if (total_out !== '0) begin fails++; $display("FAIL reset_total: got %0d, required 0", total_out); end
    tests++; if (done_out !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b, required 0", done_out); end
    tests++; if (order_err_out !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b, required 0", order_err_out); end
    tests++; if (data_ready_out !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b, required 1", data_ready_out); end
    tests++; if (fsm_state_out !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d, required 0", fsm_state_out); end
  endtask

  task automatic test_aoc_example();
    do_reset();
    exp_q.push_back(rng(3, 5));
    exp_q.push_back(rng(10, 20));
    send_beat(rng(3, 5), rng(10, 14), 1'b1);
    send_beat(rng(12, 18), rng(16, 20), 1'b1);
    finish_stream();
    collect(exp_q.size());
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL aoc_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL aoc_range[%0d]: got %h, required %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    tests++; if (total_out !== 64'd14) begin fails++; $display("FAIL aoc_total: got %0d, required 14", total_out); end
    tests++; if (done_out !== 1'b1) begin fails++; $display("FAIL aoc_done: got %0b, required 1", done_out); end
    tests++; if (order_err_out !== 1'b0) begin fails++; $display("FAIL aoc_err: got %0b, required 0", order_err_out); end
    tests++; if (data_ready_out !== 1'b0) begin fails++; $display("FAIL aoc_ready_after_done: got %0b, required 0", data_ready_out); end
  endtask

  task automatic test_adjacency();
    do_reset();
`ifdef RANGE_COALESCE_ADJ_MERGE_EN
    exp_q.push_back(rng(1, 9));
`else
    exp_q.push_back(rng(1, 4));
    exp_q.push_back(rng(5, 9));
`endif
    send_beat(rng(1, 4), rng(5, 9), 1'b1);
    finish_stream();
    collect(exp_q.size());
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL adj_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL adj_range[%0d]: got %h, required %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    tests++; if (total_out !== 64'd9) begin fails++; $display("FAIL adj_total: got %0d, required 9", total_out); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 6; k++) exp_q.push_back(rng(64'(2*k+1), 64'(2*k+1)));
    send_beat(rng(1, 1), rng(3, 3), 1'b1);
    send_beat(rng(5, 5), rng(7, 7), 1'b1);
    @(negedge clock);
    tests++; if (data_ready_out !== 1'b0) begin fails++; $display("FAIL bp_ready_low: got %0b, required 0", data_ready_out); end
    tests++; if (merged_out !== rng(1, 1)) begin fails++; $display("FAIL bp_head: got %h, required %h", merged_out, rng(1, 1)); end
    tests++; if (total_out !== 64'd3) begin fails++; $display("FAIL bp_partial_total: got %0d, required 3", total_out); end
    @(posedge clock);
    #1;
    fork
      begin
        send_beat(rng(9, 9), rng(11, 11), 1'b1);
        finish_stream();
      end
      begin
        repeat (3) @(posedge clock);
        #1;
        collect(6);
      end
    join
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL bp_range[%0d]: got %h, required %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    tests++; if (total_out !== 64'd6) begin fails++; $display("FAIL bp_total: got %0d, required 6", total_out); end
    tests++; if (merged_valid_out !== 1'b0) begin fails++; $display("FAIL bp_drained: got %0b, required 0", merged_valid_out); end
  endtask

  task automatic test_odd_invalid();
    do_reset();
    exp_q.push_back(rng(2, 8));
    send_beat(rng(2, 8), rng(0, 100), 1'b0);
    finish_stream();
    collect(1);
    tests++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin fails++; $display("FAIL odd_inv_range: got %0d entries head %h, required 1 entry %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]); end
    tests++; if (total_out !== 64'd7) begin fails++; $display("FAIL odd_inv_total: got %0d, required 7", total_out); end
    tests++; if (order_err_out !== 1'b0) begin fails++; $display("FAIL odd_inv_err: got %0b, required 0", order_err_out); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.push_back(rng(1, 6));
    exp_q.push_back(rng(8, 9));
    exp_q.push_back(rng(20, 40));
    exp_q.push_back(rng(42, 50));
    send_beat(rng(1, 3), rng(2, 6), 1'b1);
    send_beat(rng(8, 9), rng(20, 30), 1'b1);
    send_beat(rng(21, 22), rng(25, 40), 1'b1);
    send_beat(rng(42, 50), rng(0, 0), 1'b0);
    finish_stream();
    collect(exp_q.size());
    tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL b2b_range[%0d]: got %h, required %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    tests++; if (total_out !== 64'd38) begin fails++; $display("FAIL b2b_total: got %0d, required 38", total_out); end
  endtask

  task automatic test_empty_stream();
    do_reset();
    stream_done_in = 1'b1;
    @(negedge clock);
    tests++; if (done_out !== 1'b0) begin fails++; $display("FAIL empty_done_early: got %0b, required 0", done_out); end
    @(negedge clock);
    tests++; if (done_out !== 1'b1) begin fails++; $display("FAIL empty_done: got %0b, required 1", done_out); end
    tests++; if (total_out !== '0) begin fails++; $display("FAIL empty_total: got %0d, required 0", total_out); end
    tests++; if (merged_valid_out !== 1'b0) begin fails++; $display("FAIL empty_valid: got %0b, required 0", merged_valid_out); end
    tests++; if (data_ready_out !== 1'b0) begin fails++; $display("FAIL empty_ready: got %0b, required 0", data_ready_out); end
    tests++; if (fsm_state_out !== 2'd3) begin fails++; $display("FAIL empty_state: got %0d, required 3", fsm_state_out); end
  endtask

  task automatic test_edge_values();
    logic [W-1:0] ones;
    ones = '1;
    do_reset();
    exp_q.push_back(rng(0, ones));
    send_beat(rng(0, ones), rng(5, 5), 1'b0);
    send_beat(rng(ones, ones), rng(0, 0), 1'b0);
    finish_stream();
    collect(1);
    tests++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin fails++; $display("FAIL edge_range: got %0d entries head %h, required 1 entry %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]); end
    tests++; if (total_out !== '0) begin fails++; $display("FAIL edge_total_wrap: got %h, required 0", total_out); end
    tests++; if (done_out !== 1'b1) begin fails++; $display("FAIL edge_done: got %0b, required 1", done_out); end
    tests++; if (order_err_out !== 1'b0) begin fails++; $display("FAIL edge_err: got %0b, required 0", order_err_out); end
  endtask

  task automatic test_order_err_reset();
    do_reset();
    send_beat(rng(10, 12), rng(5, 6), 1'b1);
    @(negedge clock);
    tests++; if (order_err_out !== 1'b1) begin fails++; $display("FAIL order_err: got %0b, required 1", order_err_out); end
    @(posedge clock);
    #1;
    send_beat(rng(20, 25), rng(0, 0), 1'b0);
    @(negedge clock);
    tests++; if (merged_valid_out !== 1'b1) begin fails++; $display("FAIL mid_valid: got %0b, required 1", merged_valid_out); end
    tests++; if (total_out !== 64'd3) begin fails++; $display("FAIL mid_total: got %0d, required 3", total_out); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (merged_valid_out !== 1'b0) begin fails++; $display("FAIL async_valid: got %0b, required 0", merged_valid_out); end
    tests++; if (total_out !== '0) begin fails++; $display("FAIL async_total: got %0d, required 0", total_out); end
    tests++; if (order_err_out !== 1'b0) begin fails++; $display("FAIL async_err: got %0b, required 0", order_err_out); end
    tests++; if (done_out !== 1'b0) begin fails++; $display("FAIL async_done: got %0b, required 0", done_out); end
    tests++; if (fsm_state_out !== 2'd0) begin fails++; $display("FAIL async_state: got %0d, required 0", fsm_state_out); end
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    tests++; if (merged_valid_out !== 1'b0) begin fails++; $display("FAIL post_reset_valid: got %0b, required 0", merged_valid_out); end
    tests++; if (data_ready_out !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %0b, required 1", data_ready_out); end
  endtask

  initial begin
    test_reset();
    test_aoc_example();
    test_adjacency();
    test_backpressure();
    test_odd_invalid();
    test_back_to_back();
    test_empty_stream();
    test_edge_values();
    test_order_err_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
